// File: rtl/regfile_scoreboard.sv
// Register file with write-through bypass, optional hardwired-zero r0, and
// per-register pending-write counters used by ID for RAW / load-use detection.
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NREAD    = 2,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wen,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    issue_valid,
  input  logic [ADDR_W-1:0]       issue_addr,
  output logic                    issue_stall,
  input  logic                    flush,
  output logic                    any_pending
);

  localparam int unsigned     DEPTH   = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs     [DEPTH];
  logic [CNT_W-1:0]  cnt      [DEPTH];
  logic [CNT_W-1:0]  cnt_next [DEPTH];
  logic              issue_zero;
  logic              write_zero;
  logic              pend_now;

  assign issue_zero = (ZERO_REG != 0) && (issue_addr == '0);
  assign write_zero = (ZERO_REG != 0) && (waddr == '0);

  // A retire to the same register in this cycle frees a slot for the issue.
  assign issue_stall = issue_valid && !issue_zero && (cnt[issue_addr] == CNT_MAX)
                       && !(wen && (waddr == issue_addr));

  always_comb begin
    logic inc;
    logic dec;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      inc = issue_valid && (issue_addr == ADDR_W'(r)) && !issue_stall && !issue_zero;
      dec = wen && (waddr == ADDR_W'(r)) && (cnt[r] != '0);
      cnt_next[r] = cnt[r];
      if (flush)
        cnt_next[r] = '0;
      else if (inc && !dec)
        cnt_next[r] = cnt[r] + CNT_ONE;
      else if (dec && !inc)
        cnt_next[r] = cnt[r] - CNT_ONE;
    end
  end

  always_comb begin
    pend_now = 1'b0;
    for (int unsigned r = 0; r < DEPTH; r++)
      pend_now = pend_now | (cnt[r] != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      any_pending <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++)
        cnt[r] <= cnt_next[r];
      if (wen && !write_zero)
        regs[waddr] <= wdata;
      any_pending <= pend_now;
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero_hit;
    logic              wr_hit;

    assign a        = rd_addr[k*ADDR_W +: ADDR_W];
    assign zero_hit = (ZERO_REG != 0) && (a == '0);
    assign wr_hit   = wen && (waddr == a);

    assign rd_data[k*DATA_W +: DATA_W] = zero_hit ? '0 : (wr_hit ? wdata : regs[a]);
    // The last outstanding write retiring now is satisfied through the bypass.
    assign rd_busy[k] = !zero_hit && (cnt[a] != '0) && !(wr_hit && (cnt[a] == CNT_ONE));
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed scenarios plus random
// traffic, checked against an array-based reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wen;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        issue_valid;
  logic [3:0]  issue_addr;
  logic        issue_stall;
  logic        flush;
  logic        any_pending;

  always #5 clk = ~clk;

  regfile_scoreboard #(
    .DATA_W(16), .ADDR_W(4), .NREAD(2), .CNT_W(2), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wen(wen), .waddr(waddr), .wdata(wdata), .issue_valid(issue_valid),
    .issue_addr(issue_addr), .issue_stall(issue_stall), .flush(flush),
    .any_pending(any_pending)
  );

  typedef struct {
    logic [15:0] d0;
    logic [15:0] d1;
    logic        b0;
    logic        b1;
    logic        stall;
    logic        pend;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain arrays, rules applied per clock.
  int m_mem [16];
  int m_cnt [16];
  int m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 0;
      m_cnt[i] = 0;
    end
    m_pend = 0;
  endfunction

  function automatic int m_read(input int a);
    if (a == 0) return 0;
    if (wen && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  function automatic bit m_busy(input int a);
    if (a == 0) return 0;
    return (m_cnt[a] > 0) && !(wen && waddr == a && m_cnt[a] == 1);
  endfunction

  function automatic bit m_stall();
    return issue_valid && issue_addr != 0 && m_cnt[issue_addr] == 3
           && !(wen && waddr == issue_addr);
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    e.d0    = 16'(m_read(int'(rd_addr[3:0])));
    e.d1    = 16'(m_read(int'(rd_addr[7:4])));
    e.b0    = m_busy(int'(rd_addr[3:0]));
    e.b1    = m_busy(int'(rd_addr[7:4]));
    e.stall = m_stall();
    e.pend  = (m_pend != 0);
    return e;
  endfunction

  function automatic void model_step();
    bit accept;
    bit retire;
    int any;
    any = 0;
    for (int i = 0; i < 16; i++) if (m_cnt[i] != 0) any = 1;
    accept = issue_valid && issue_addr != 0 && !m_stall();
    retire = wen && m_cnt[waddr] != 0;
    if (flush) begin
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    end else begin
      if (accept) m_cnt[issue_addr] = m_cnt[issue_addr] + 1;
      if (retire) m_cnt[waddr] = m_cnt[waddr] - 1;
    end
    if (wen && waddr != 0) m_mem[waddr] = wdata;
    m_pend = any;
  endfunction

  // Called at a falling edge: apply inputs, queue what the model expects.
  task automatic drive(input logic [3:0] r0, input logic [3:0] r1, input logic we,
                       input logic [3:0] wa, input logic [15:0] wd, input logic iv,
                       input logic [3:0] ia, input logic fl);
    rd_addr     = {r1, r0};
    wen         = we;
    waddr       = wa;
    wdata       = wd;
    issue_valid = iv;
    issue_addr  = ia;
    flush       = fl;
    #1;
    q.push_back(model_expect());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic step(input logic [3:0] r0, input logic [3:0] r1, input logic we,
                      input logic [3:0] wa, input logic [15:0] wd, input logic iv,
                      input logic [3:0] ia, input logic fl);
    drive(r0, r1, we, wa, wd, iv, ia, fl);
    tick();
  endtask

  // Monitor: outputs are combinational every cycle; compare mid low phase.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check("sb_rd_data0", 32'(rd_data[15:0]), 32'(mon_e.d0));
        check("sb_rd_data1", 32'(rd_data[31:16]), 32'(mon_e.d1));
        check("sb_rd_busy0", 32'(rd_busy[0]), 32'(mon_e.b0));
        check("sb_rd_busy1", 32'(rd_busy[1]), 32'(mon_e.b1));
        check("sb_issue_stall", 32'(issue_stall), 32'(mon_e.stall));
        check("sb_any_pending", 32'(any_pending), 32'(mon_e.pend));
      end
    end
  end

  initial begin
    rst = 1'b0;
    rd_addr = '0; wen = 1'b0; waddr = '0; wdata = '0;
    issue_valid = 1'b0; issue_addr = '0; flush = 1'b0;
    model_reset();
    #2;
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_any_pending", 32'(any_pending), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Every address reads zero and idle after reset.
    for (int a = 0; a < 16; a++) begin
      drive(4'(a), 4'(15 - a), 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
      check("post_reset_rd_data", rd_data, 32'h0);
      check("post_reset_busy", 32'(rd_busy), 32'h0);
      tick();
    end

    // Write-through bypass, then registered value.
    drive(4'd3, 4'd0, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'h0, 1'b0);
    check("bypass_rd0", 32'(rd_data[15:0]), 32'hBEEF);
    tick();
    drive(4'd3, 4'd3, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    check("stored_rd0", 32'(rd_data[15:0]), 32'hBEEF);
    check("stored_rd1", 32'(rd_data[31:16]), 32'hBEEF);
    tick();

    // Register 0 ignores writes and issues.
    drive(4'd0, 4'd0, 1'b1, 4'd0, 16'h1234, 1'b0, 4'h0, 1'b0);
    check("zero_bypass", rd_data, 32'h0);
    tick();
    drive(4'd0, 4'd0, 1'b0, 4'h0, 16'h0, 1'b1, 4'd0, 1'b0);
    check("zero_busy", 32'(rd_busy), 32'h0);
    tick();
    step(4'd0, 4'd0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    drive(4'd0, 4'd0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    check("zero_rd", rd_data, 32'h0);
    check("zero_any_pending", 32'(any_pending), 32'h0);
    tick();

    // Two outstanding writes to r5, retired one at a time.
    step(4'd5, 4'd0, 1'b0, 4'h0, 16'h0, 1'b1, 4'd5, 1'b0);
    step(4'd5, 4'd0, 1'b0, 4'h0, 16'h0, 1'b1, 4'd5, 1'b0);
    drive(4'd5, 4'd0, 1'b1, 4'd5, 16'h5151, 1'b0, 4'h0, 1'b0);
    check("r5_busy_first_wb", 32'(rd_busy[0]), 32'h1);
    tick();
    drive(4'd5, 4'd0, 1'b1, 4'd5, 16'h5252, 1'b0, 4'h0, 1'b0);
    check("r5_busy_last_wb", 32'(rd_busy[0]), 32'h0);
    check("r5_bypass_last_wb", 32'(rd_data[15:0]), 32'h5252);
    tick();
    drive(4'd5, 4'd0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    check("r5_pending_lag", 32'(any_pending), 32'h1);
    tick();
    drive(4'd5, 4'd0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    check("r5_pending_clear", 32'(any_pending), 32'h0);
    tick();

    // Saturate r7.
    for (int i = 0; i < 3; i++) step(4'd7, 4'd0, 1'b0, 4'h0, 16'h0, 1'b1, 4'd7, 1'b0);
    drive(4'd7, 4'd0, 1'b0, 4'h0, 16'h0, 1'b1, 4'd7, 1'b0);
    check("r7_stall", 32'(issue_stall), 32'h1);
    tick();
    drive(4'd7, 4'd0, 1'b0, 4'h0, 16'h0, 1'b1, 4'd7, 1'b0);
    check("r7_stall_again", 32'(issue_stall), 32'h1);
    tick();
    drive(4'd7, 4'd0, 1'b1, 4'd7, 16'h7777, 1'b1, 4'd7, 1'b0);
    check("r7_stall_retire", 32'(issue_stall), 32'h0);
    tick();

    // Flush with concurrent write to r2.
    step(4'd2, 4'd9, 1'b0, 4'h0, 16'h0, 1'b1, 4'd2, 1'b0);
    step(4'd2, 4'd9, 1'b0, 4'h0, 16'h0, 1'b1, 4'd9, 1'b0);
    step(4'd2, 4'd9, 1'b0, 4'h0, 16'h0, 1'b1, 4'd9, 1'b0);
    drive(4'd2, 4'd9, 1'b1, 4'd2, 16'h00AA, 1'b1, 4'd4, 1'b1);
    check("flush_busy9", 32'(rd_busy[1]), 32'h1);
    tick();
    drive(4'd2, 4'd7, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    check("flush_rd2", 32'(rd_data[15:0]), 32'h00AA);
    check("flush_busy", 32'(rd_busy), 32'h0);
    tick();
    drive(4'd9, 4'd4, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    check("flush_any_pending", 32'(any_pending), 32'h0);
    tick();

    // Issue r4, then asynchronous reset between edges.
    step(4'd2, 4'd4, 1'b0, 4'h0, 16'h0, 1'b1, 4'd4, 1'b0);
    step(4'd2, 4'd4, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    rd_addr = {4'd4, 4'd2};
    wen = 1'b0; issue_valid = 1'b0; flush = 1'b0;
    #1;
    check("pre_reset_busy4", 32'(rd_busy[1]), 32'h1);
    check("pre_reset_pending", 32'(any_pending), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset_rd_data", rd_data, 32'h0);
    check("async_reset_busy", 32'(rd_busy), 32'h0);
    check("async_reset_stall", 32'(issue_stall), 32'h0);
    check("async_reset_pending", 32'(any_pending), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);

    // Random traffic on a narrow address range to force collisions.
    for (int i = 0; i < 600; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 40), 4'($urandom_range(0, 7)), 16'($urandom()),
           ($urandom_range(0, 99) < 60), 4'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 3));
    end

    drive(4'd0, 4'd0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 1'b0);
    tick();
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
